// File: rtl/furv_if_q_pkg.sv
// Shared opcodes and decode helpers for the furv fetch stage.
// FURV_IF_JAL_EN (in furv_if_q) is the only consumer of the JAL helpers.
package furv_pkg;

    localparam int INSTR_W = 32;

    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    // J-type immediate, already sign-extended to 32 bits with bit 0 forced to zero
    function automatic logic [31:0] j_imm(input logic [31:0] instr);
        return {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
    endfunction

endpackage

// File: rtl/furv_if_q_if.sv
// Fetch-stage bus: instruction memory side, decode side and execute redirect.
interface furv_if_q_if #(parameter int XLEN = 32);

    logic [XLEN-1:0] pc;
    logic [31:0]     instruction_i;
    logic            valid_i;
    logic            stall_o;
    logic [XLEN-1:0] if_pc;
    logic [31:0]     instruction;
    logic            pred_taken;
    logic            valid_o;
    logic            stall_i;
    logic            branch_calculated;
    logic            branch_taken;
    logic [XLEN-1:0] branch_pc;

    modport master (
        output pc, stall_o, if_pc, instruction, pred_taken, valid_o,
        input  instruction_i, valid_i, stall_i, branch_calculated, branch_taken, branch_pc
    );

    modport slave (
        input  pc, stall_o, if_pc, instruction, pred_taken, valid_o,
        output instruction_i, valid_i, stall_i, branch_calculated, branch_taken, branch_pc
    );

endinterface

// File: rtl/furv_if_q_fifo.sv
// Generic synchronous FIFO with registered storage and combinational head.
// DEPTH must be a power of two so the pointers wrap naturally.
module furv_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/furv_if_q.sv
// Fetch stage with prefetch queue; halts after control instructions until execute resolves them.
// Define FURV_IF_JAL_EN to redirect JALs directly in fetch instead of waiting.
module furv_if_q
    import furv_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input logic          clk,
    input logic          rst,
    furv_if_q_if.master  bus
);

    typedef struct packed {
        logic [XLEN-1:0]    pc;
        logic [INSTR_W-1:0] instr;
        logic               pred;
    } entry_t;

    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] next_pc;
    logic            wait_q;
    logic            wait_next;
    logic            jal_hit;
    logic            redirect;
    logic            fetch_en;
    logic            push;
    logic            pop;
    logic            full;
    logic            empty;
    entry_t          din;
    entry_t          head;
    logic            unused_bits;

    assign unused_bits = ^bus.branch_pc[1:0];

    // A resolution only counts while a control instruction is outstanding
    assign redirect    = wait_q && bus.branch_calculated && bus.branch_taken;
    assign bus.pc      = redirect ? {bus.branch_pc[XLEN-1:2], 2'b00} : pc_q;
    assign fetch_en    = !full && (!wait_q || bus.branch_calculated);
    assign bus.stall_o = !fetch_en;
    assign push        = fetch_en && bus.valid_i;
    assign pop         = !empty && !bus.stall_i;

`ifdef FURV_IF_JAL_EN
    assign jal_hit   = (bus.instruction_i[6:0] == OPC_JAL);
    assign next_pc   = jal_hit ? bus.pc + XLEN'(signed'(j_imm(bus.instruction_i)))
                               : bus.pc + XLEN'(4);
    assign wait_next = bus.instruction_i[6] && !jal_hit;
`else
    assign jal_hit   = 1'b0;
    assign next_pc   = bus.pc + XLEN'(4);
    assign wait_next = bus.instruction_i[6];
`endif

    assign din = '{pc: bus.pc, instr: bus.instruction_i, pred: jal_hit};

    // A resolution arriving while the queue is full still clears the wait and latches its target
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q   <= RESET_PC;
            wait_q <= 1'b0;
        end else if (push) begin
            pc_q   <= next_pc;
            wait_q <= wait_next;
        end else if (fetch_en || bus.branch_calculated) begin
            pc_q   <= bus.pc;
            wait_q <= 1'b0;
        end
    end

    furv_fifo #(
        .WIDTH ($bits(entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (din),
        .head  (head),
        .full  (full),
        .empty (empty)
    );

    assign bus.valid_o     = !empty;
    assign bus.if_pc       = head.pc;
    assign bus.instruction = head.instr;
    assign bus.pred_taken  = head.pred;

endmodule

// File: tb/tb_furv_if_q.sv
// Directed self-checking bench for furv_if_q (DEPTH=4, RESET_PC=0, XLEN=32).
// Instruction memory is a combinational word array indexed by the fetch PC.
module tb_furv_if_q;

    localparam logic [31:0] ADDI    = 32'h0000_0013;
    localparam logic [31:0] BEQ     = 32'h0000_0063;
    localparam logic [31:0] JAL_100 = 32'h1000_006F;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] imem [256];
    int          checks = 0;
    int          passed = 0;

    furv_if_q_if #(.XLEN(32)) bus ();

    furv_if_q #(
        .XLEN     (32),
        .DEPTH    (4),
        .RESET_PC (32'h0)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    assign bus.instruction_i = imem[bus.pc[9:2]];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_imem();
        for (int i = 0; i < 256; i++) imem[i] = ADDI;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.valid_i = 1'b1;
        bus.stall_i = 1'b0;
        bus.branch_calculated = 1'b0;
        bus.branch_taken = 1'b0;
        bus.branch_pc = '0;
        step();
        step();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        clear_imem();
        do_reset();
        checks++; if (bus.valid_o !== 1'b0) $display("[TB] FAIL reset_valid_o: got %b want 0", bus.valid_o); else passed++;
        checks++; if (bus.stall_o !== 1'b0) $display("[TB] FAIL reset_stall_o: got %b want 0", bus.stall_o); else passed++;
        checks++; if (bus.pc !== 32'h0) $display("[TB] FAIL reset_pc: got %h want 00000000", bus.pc); else passed++;
    endtask

    task automatic test_sequential();
        clear_imem();
        do_reset();
        for (int i = 0; i < 6; i++) begin
            checks++; if (bus.pc !== 32'(4*i)) $display("[TB] FAIL seq_pc[%0d]: got %h want %h", i, bus.pc, 32'(4*i)); else passed++;
            if (i == 0) begin
                checks++; if (bus.valid_o !== 1'b0) $display("[TB] FAIL seq_valid0: got %b want 0", bus.valid_o); else passed++;
            end else begin
                checks++; if (bus.valid_o !== 1'b1) $display("[TB] FAIL seq_valid[%0d]: got %b want 1", i, bus.valid_o); else passed++;
                checks++; if (bus.if_pc !== 32'(4*(i-1))) $display("[TB] FAIL seq_if_pc[%0d]: got %h want %h", i, bus.if_pc, 32'(4*(i-1))); else passed++;
            end
            step();
        end
    endtask

    task automatic test_full();
        clear_imem();
        do_reset();
        bus.stall_i = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) begin
            checks++; if (bus.pc !== 32'(4*i)) $display("[TB] FAIL fill_pc[%0d]: got %h want %h", i, bus.pc, 32'(4*i)); else passed++;
            checks++; if (bus.stall_o !== 1'b0) $display("[TB] FAIL fill_stall_o[%0d]: got %b want 0", i, bus.stall_o); else passed++;
            step();
        end
        checks++; if (bus.stall_o !== 1'b1) $display("[TB] FAIL full_stall_o: got %b want 1", bus.stall_o); else passed++;
        checks++; if (bus.pc !== 32'h10) $display("[TB] FAIL full_pc: got %h want 00000010", bus.pc); else passed++;
        step();
        checks++; if (bus.pc !== 32'h10) $display("[TB] FAIL full_pc_hold: got %h want 00000010", bus.pc); else passed++;
        checks++; if (bus.if_pc !== 32'h0) $display("[TB] FAIL full_head: got %h want 00000000", bus.if_pc); else passed++;
        bus.stall_i = 1'b0;
        #1;
        for (int k = 0; k < 5; k++) begin
            checks++; if (bus.if_pc !== 32'(4*k)) $display("[TB] FAIL drain_if_pc[%0d]: got %h want %h", k, bus.if_pc, 32'(4*k)); else passed++;
            if (k == 1) begin
                checks++; if (bus.pc !== 32'h10) $display("[TB] FAIL resume_pc: got %h want 00000010", bus.pc); else passed++;
                checks++; if (bus.stall_o !== 1'b0) $display("[TB] FAIL resume_stall_o: got %b want 0", bus.stall_o); else passed++;
            end
            step();
        end
    endtask

    task automatic test_branch(input logic taken);
        logic [31:0] target;
        target = taken ? 32'h40 : 32'h0C;
        clear_imem();
        imem[2] = BEQ;
        do_reset();
        step();
        step();
        checks++; if (bus.pc !== 32'h8) $display("[TB] FAIL br_fetch_pc: got %h want 00000008", bus.pc); else passed++;
        step();
        checks++; if (bus.stall_o !== 1'b1) $display("[TB] FAIL br_wait_stall1: got %b want 1", bus.stall_o); else passed++;
        checks++; if (bus.if_pc !== 32'h8) $display("[TB] FAIL br_head: got %h want 00000008", bus.if_pc); else passed++;
        step();
        checks++; if (bus.stall_o !== 1'b1) $display("[TB] FAIL br_wait_stall2: got %b want 1", bus.stall_o); else passed++;
        checks++; if (bus.valid_o !== 1'b0) $display("[TB] FAIL br_wait_empty: got %b want 0", bus.valid_o); else passed++;
        step();
        bus.branch_calculated = 1'b1;
        bus.branch_taken = taken;
        bus.branch_pc = 32'h43;
        #1;
        checks++; if (bus.pc !== target) $display("[TB] FAIL br_resolve_pc: got %h want %h", bus.pc, target); else passed++;
        checks++; if (bus.stall_o !== 1'b0) $display("[TB] FAIL br_resolve_stall: got %b want 0", bus.stall_o); else passed++;
        step();
        bus.branch_calculated = 1'b0;
        bus.branch_taken = 1'b0;
        #1;
        checks++; if (bus.if_pc !== target) $display("[TB] FAIL br_target_head: got %h want %h", bus.if_pc, target); else passed++;
        checks++; if (bus.pc !== target + 32'h4) $display("[TB] FAIL br_after_pc: got %h want %h", bus.pc, target + 32'h4); else passed++;
        if (!taken) begin
            bus.branch_calculated = 1'b1;
            bus.branch_taken = 1'b1;
            bus.branch_pc = 32'h80;
            #1;
            checks++; if (bus.pc !== 32'h10) $display("[TB] FAIL spurious_pc: got %h want 00000010", bus.pc); else passed++;
            checks++; if (bus.stall_o !== 1'b0) $display("[TB] FAIL spurious_stall: got %b want 0", bus.stall_o); else passed++;
            step();
            bus.branch_calculated = 1'b0;
            bus.branch_taken = 1'b0;
            #1;
            checks++; if (bus.pc !== 32'h14) $display("[TB] FAIL spurious_next_pc: got %h want 00000014", bus.pc); else passed++;
            checks++; if (bus.if_pc !== 32'h10) $display("[TB] FAIL spurious_head: got %h want 00000010", bus.if_pc); else passed++;
        end
    endtask

    task automatic test_jal();
        clear_imem();
        imem[8] = JAL_100;
        do_reset();
        for (int i = 0; i < 8; i++) step();
        checks++; if (bus.pc !== 32'h20) $display("[TB] FAIL jal_fetch_pc: got %h want 00000020", bus.pc); else passed++;
        step();
        checks++; if (bus.if_pc !== 32'h20) $display("[TB] FAIL jal_head: got %h want 00000020", bus.if_pc); else passed++;
`ifdef FURV_IF_JAL_EN
        checks++; if (bus.pc !== 32'h120) $display("[TB] FAIL jal_target_pc: got %h want 00000120", bus.pc); else passed++;
        checks++; if (bus.stall_o !== 1'b0) $display("[TB] FAIL jal_no_wait: got %b want 0", bus.stall_o); else passed++;
        checks++; if (bus.pred_taken !== 1'b1) $display("[TB] FAIL jal_pred: got %b want 1", bus.pred_taken); else passed++;
        step();
        checks++; if (bus.if_pc !== 32'h120) $display("[TB] FAIL jal_target_head: got %h want 00000120", bus.if_pc); else passed++;
        checks++; if (bus.pred_taken !== 1'b0) $display("[TB] FAIL jal_target_pred: got %b want 0", bus.pred_taken); else passed++;
`else
        checks++; if (bus.pc !== 32'h24) $display("[TB] FAIL jal_wait_pc: got %h want 00000024", bus.pc); else passed++;
        checks++; if (bus.stall_o !== 1'b1) $display("[TB] FAIL jal_wait: got %b want 1", bus.stall_o); else passed++;
        checks++; if (bus.pred_taken !== 1'b0) $display("[TB] FAIL jal_pred: got %b want 0", bus.pred_taken); else passed++;
        bus.branch_calculated = 1'b1;
        bus.branch_taken = 1'b1;
        bus.branch_pc = 32'h120;
        #1;
        checks++; if (bus.pc !== 32'h120) $display("[TB] FAIL jal_resolve_pc: got %h want 00000120", bus.pc); else passed++;
        step();
        bus.branch_calculated = 1'b0;
        bus.branch_taken = 1'b0;
        #1;
        checks++; if (bus.if_pc !== 32'h120) $display("[TB] FAIL jal_target_head: got %h want 00000120", bus.if_pc); else passed++;
`endif
    endtask

    task automatic test_mid_reset();
        clear_imem();
        imem[2] = BEQ;
        do_reset();
        bus.stall_i = 1'b1;
        step();
        step();
        step();
        checks++; if (bus.valid_o !== 1'b1) $display("[TB] FAIL mr_pre_valid: got %b want 1", bus.valid_o); else passed++;
        checks++; if (bus.stall_o !== 1'b1) $display("[TB] FAIL mr_pre_stall: got %b want 1", bus.stall_o); else passed++;
        rst = 1'b1;
        step();
        checks++; if (bus.valid_o !== 1'b0) $display("[TB] FAIL mr_valid_o: got %b want 0", bus.valid_o); else passed++;
        checks++; if (bus.pc !== 32'h0) $display("[TB] FAIL mr_pc: got %h want 00000000", bus.pc); else passed++;
        checks++; if (bus.stall_o !== 1'b0) $display("[TB] FAIL mr_stall_o: got %b want 0", bus.stall_o); else passed++;
        rst = 1'b0;
        bus.stall_i = 1'b0;
        step();
        checks++; if (bus.if_pc !== 32'h0) $display("[TB] FAIL mr_restart_head: got %h want 00000000", bus.if_pc); else passed++;
        checks++; if (bus.pc !== 32'h4) $display("[TB] FAIL mr_restart_pc: got %h want 00000004", bus.pc); else passed++;
    endtask

    initial begin
        rst = 1'b1;
        bus.valid_i = 1'b0;
        bus.stall_i = 1'b0;
        bus.branch_calculated = 1'b0;
        bus.branch_taken = 1'b0;
        bus.branch_pc = '0;
        test_reset();
        test_sequential();
        test_full();
        test_branch(1'b1);
        test_branch(1'b0);
        test_jal();
        test_mid_reset();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
